// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver.
//   tx_state_t      : transmitter FSM states (3-bit encoding)
//   LINE_IDLE       : level of the serial line between frames
//   clocks_per_bit(): system clocks per bit period (integer division)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    function automatic int unsigned clocks_per_bit(input int unsigned clock_frequency,
                                                   input int unsigned baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Bit-period timer shared by the UART transmitter and receiver. While en is
// high it counts 0..CLOCKS_PER_BIT-1 and wraps; the wrap cycle is flagged on
// wrap. Dropping en clears the count so the next bit period starts at 0.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   en    in  count enable
//   wrap  out high for the last cycle of each bit period (combinational)
// -----------------------------------------------------------------------------
module uart_baud_counter #(
    parameter int unsigned CLOCKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic wrap
);

    localparam logic [31:0] LAST_COUNT = 32'(CLOCKS_PER_BIT - 1);

    logic [31:0] count;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (!en || count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

    assign wrap = en && (count == LAST_COUNT);

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// Pulls words from a TX FIFO and serialises them onto the UART line:
// start bit (0), WORD_WIDTH data bits LSB first, optional even parity bit,
// STOP_BITS stop bits (1). The line idles high.
// Optional feature: define UART_TX_PARITY_EN to insert the even parity bit.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-low reset
//   din    in  FIFO read data, valid the cycle after re
//   empty  in  FIFO empty flag
//   re     out FIFO read enable, single-cycle pulse issued from IDLE
//   dout   out serial TX line (flop output)
//   busy   out high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
    parameter int unsigned BAUD_RATE       = 32'd115200,
    parameter int unsigned WORD_WIDTH      = 32'd8,
    parameter int unsigned STOP_BITS       = 32'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] din,
    input  logic                  empty,
    output logic                  re,
    output logic                  dout,
    output logic                  busy
);

    localparam int unsigned CLOCKS_PER_BIT = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);

    if (CLOCKS_PER_BIT < 2) begin : g_bad_clocks_per_bit
        $error("uart_transmitter: CLOCKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end

    tx_state_t             state, state_next;
    logic [WORD_WIDTH-1:0] shift, shift_next;
    logic [WORD_WIDTH:0]   shift_ext;
    logic [31:0]           bit_cnt, bit_cnt_next;
    logic                  dout_next;
    logic                  count_en;
    logic                  bit_end;
`ifdef UART_TX_PARITY_EN
    logic                  parity, parity_next;
`endif

    assign count_en = state inside {START, DATA, PARITY, STOP};
    assign busy     = (state != IDLE);

    uart_baud_counter #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_baud_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (count_en),
        .wrap (bit_end)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        dout_next    = dout;
        re           = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity;
`endif
        // Idle-filled view of the shift register; bit 1 is the next data bit.
        shift_ext    = {LINE_IDLE, shift};

        case (state)
            IDLE: begin
                dout_next    = LINE_IDLE;
                bit_cnt_next = '0;
                if (!empty) begin
                    // Gated by rst so no word is popped while held in reset.
                    re         = rst;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                shift_next   = din;
                bit_cnt_next = '0;
                dout_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_next  = ^din;
`endif
                state_next   = START;
            end
            START: begin
                if (bit_end) begin
                    dout_next  = shift[0];
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_ext[WORD_WIDTH:1];
                    if (bit_cnt == WORD_WIDTH - 1) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        dout_next    = parity;
                        state_next   = PARITY;
`else
                        dout_next    = LINE_IDLE;
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + 32'd1;
                        dout_next    = shift_ext[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    dout_next  = LINE_IDLE;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                dout_next = LINE_IDLE;
                if (bit_end) begin
                    if (bit_cnt == STOP_BITS - 1) begin
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt + 32'd1;
                    end
                end
            end
            default: begin
                dout_next  = LINE_IDLE;
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: the shift register is a plain flop bank, not a RAM, so giving it
    // an async reset value costs nothing and keeps the idle line defined.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shift   <= '1;
            bit_cnt <= '0;
            dout    <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_cnt <= bit_cnt_next;
            dout    <= dout_next;
`ifdef UART_TX_PARITY_EN
            parity  <= parity_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Self-checking bench for uart_transmitter at 1 MHz / 100 kBd (10 clocks/bit).
// A FIFO model feeds the DUT; every pushed byte is also queued as expected
// output. A line monitor detects each start bit, pops the expected byte and
// compares the line level on every cycle of the frame against an independent
// frame model, then compares the decoded byte.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = 1 + 8 + PAR + 1;
    localparam int FRAME = NBITS * CPB;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [7:0] din   = 8'h00;
    logic       empty = 1'b1;
    logic       re;
    logic       dout;
    logic       busy;

    uart_transmitter #(
        .CLOCK_FREQUENCY (32'd1_000_000),
        .BAUD_RATE       (32'd100_000),
        .WORD_WIDTH      (32'd8),
        .STOP_BITS       (32'd1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .empty (empty),
        .re    (re),
        .dout  (dout),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, want);
        end
    endtask

    // ---------------- FIFO model and scoreboard ----------------
    logic [7:0] fifo_mem[$];
    logic [7:0] exp_q[$];
    int         rd_ptr = 0;
    int         rp_next;
    int         n_push = 0;

    task automatic push(input logic [7:0] b);
        fifo_mem.push_back(b);
        exp_q.push_back(b);
        n_push++;
    endtask

    always @(posedge clk) begin
        rp_next = rd_ptr;
        if (re && rd_ptr < fifo_mem.size()) begin
            din     <= fifo_mem[rd_ptr];
            rp_next = rd_ptr + 1;
        end
        rd_ptr <= rp_next;
        empty  <= (rp_next >= fifo_mem.size());
    end

    // ---------------- Line monitor ----------------
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR == 1 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    logic       mon_active  = 1'b0;
    int         mon_start   = 0;
    logic [7:0] mon_exp     = 8'h00;
    logic [7:0] rx          = 8'h00;
    int         prev_last   = -1000;
    int         last_gap    = 0;
    int         last_re_cyc = -1000;
    int         re_cnt      = 0;
    int         frames_done = 0;
    int         off;

    always @(negedge clk) begin
        if (re) begin
            last_re_cyc = cyc;
            re_cnt++;
        end
        if (empty) check("re_while_empty", {31'd0, re}, 32'd0);

        if (!rst) begin
            check("dout_in_reset", {31'd0, dout}, 32'd1);
            check("busy_in_reset", {31'd0, busy}, 32'd0);
            mon_active = 1'b0;
        end else begin
            if (!mon_active && dout == 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    mon_exp = 8'h00;
                end else begin
                    mon_exp = exp_q.pop_front();
                end
                check("re_to_start_latency", 32'(cyc - last_re_cyc), 32'd2);
                last_gap   = cyc - prev_last;
                mon_start  = cyc;
                mon_active = 1'b1;
            end else if (!mon_active && prev_last == cyc - 1) begin
                check("busy_after_frame", {31'd0, busy}, 32'd0);
            end

            if (mon_active) begin
                off = cyc - mon_start;
                check("line_level", {31'd0, dout}, {31'd0, frame_bit(mon_exp, off / CPB)});
                check("busy_in_frame", {31'd0, busy}, 32'd1);
                if (off % CPB == CPB / 2 && off / CPB >= 1 && off / CPB <= 8)
                    rx[off / CPB - 1] = dout;
                if (off == FRAME - 1) begin
                    check("rx_byte", {24'd0, rx}, {24'd0, mon_exp});
                    mon_active = 1'b0;
                    prev_last  = cyc;
                    frames_done++;
                end
            end
        end
    end

    task automatic wait_frames(input int n);
        int target;
        int budget;
        int t;
        target = frames_done + n;
        budget = n * (FRAME + 10) + 100;
        t = 0;
        while (frames_done < target && t < budget) begin
            @(posedge clk);
            t++;
        end
        check("frames_done", 32'(frames_done), 32'(target));
    endtask

    // ---------------- Stimulus ----------------
    int re_base;
    int t_re;

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dout", {31'd0, dout}, 32'd1);
        check("reset_re", {31'd0, re}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;

        // Empty FIFO: line must stay idle.
        repeat (1000) begin
            @(negedge clk);
            check("idle_re", {31'd0, re}, 32'd0);
            check("idle_dout", {31'd0, dout}, 32'd1);
            check("idle_busy", {31'd0, busy}, 32'd0);
        end

        // Single frame.
        re_base = re_cnt;
        push(8'h55);
        wait_frames(1);
        check("re_pulses_single", 32'(re_cnt - re_base), 32'd1);

        // Back-to-back frames: start follows last stop cycle by 3 (2 idle-high).
        re_base = re_cnt;
        push(8'hA5);
        push(8'h3C);
        wait_frames(2);
        check("back_to_back_gap", 32'(last_gap), 32'd3);
        check("re_pulses_pair", 32'(re_cnt - re_base), 32'd2);

        // Reset in the middle of a 0x00 frame, then a clean 0x81 frame.
        @(negedge clk);
        push(8'h00);
        t_re = 0;
        do begin
            @(negedge clk);
            t_re++;
        end while (!re && t_re < 50);
        check("reset_test_re_seen", {31'd0, re}, 32'd1);
        repeat (40) @(posedge clk);
        #2;
        check("dout_before_reset", {31'd0, dout}, 32'd0);
        rst = 1'b0;
        #1;
        check("async_reset_dout", {31'd0, dout}, 32'd1);
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        check("async_reset_re", {31'd0, re}, 32'd0);
        push(8'h81);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_frames(1);

        // Stream: corner bytes plus a random run.
        push(8'h00);
        push(8'hFF);
        push(8'h80);
        push(8'h07);
        for (int i = 0; i < 256; i++) push(8'($urandom_range(0, 255)));
        wait_frames(260);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("re_total", 32'(re_cnt), 32'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
